alu_issue: RTL
==============

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-low.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  decoded ALU instruction present.
REQ-005 in_ready  output  1  block can accept an instruction this cycle.
REQ-006 funct3  input  3  RISC-V funct3 field.
REQ-007 funct7_5  input  1  instruction bit 30 (sub/sra select).
REQ-008 is_imm  input  1  1 = OP-IMM form, 0 = OP register form.
REQ-009 rs1_val  input  64  source operand 1 value.
REQ-010 rs2_val  input  64  source operand 2 value.
REQ-011 imm  input  64  sign-extended immediate.
REQ-012 flush  input  1  discard all buffered instructions.
REQ-013 out_valid  output  1  ia/ib/aluOp hold a valid ALU operation.
REQ-014 out_ready  input  1  ALU stage consumes the head entry this cycle.
REQ-015 ia  output  64  ALU operand A.
REQ-016 ib  output  64  ALU operand B.
REQ-017 aluOp  output  3  ALU operation code.
REQ-018 illegal  output  1  head entry has an unsupported funct3.

Function
REQ-019 aluOp encoding SHALL be: 000 add, 001 sub, 010 xor, 011 or, 100 and, 101 sll, 110 srl, 111 sra.
REQ-020 funct3 decode SHALL be:
- 000: add; sub when is_imm=0 and funct7_5=1.
- 100: xor.
- 110: or.
- 111: and.
- 001: sll.
- 101: srl when funct7_5=0; sra when funct7_5=1.
REQ-021 funct3 010 or 011 SHALL produce aluOp=000 and set the entry's illegal bit to 1.
REQ-022 ia SHALL equal rs1_val.
REQ-023 ib SHALL equal rs2_val when is_imm=0, and imm when is_imm=1.
REQ-024 For shift operations, ib SHALL be {58'b0, source[5:0]}, where source is rs2_val or imm per REQ-023.
REQ-025 Decode SHALL occur at enqueue; each buffer entry stores ia, ib, aluOp and illegal.
REQ-026 The buffer SHALL be a 2-entry FIFO with states EMPTY, ONE and FULL.
REQ-027 Push SHALL be in_valid && in_ready; pop SHALL be out_valid && out_ready.
REQ-028 State transitions:
- EMPTY: push -> ONE.
- ONE: push only -> FULL; pop only -> EMPTY; push and pop -> ONE.
- FULL: pop -> ONE.
REQ-029 in_ready SHALL be 1 when not FULL.
REQ-030 in_ready SHALL be derived from registered state only, with no combinational path from out_ready.
REQ-031 out_valid SHALL be 1 when not EMPTY; outputs SHALL present the oldest entry.
REQ-032 Latency: an instruction pushed at edge N SHALL be visible on the outputs with out_valid=1 after edge N, provided no older entry is pending.
REQ-033 Sustained throughput SHALL be one instruction per cycle when out_ready is held 1.
REQ-034 Head outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-035 flush=1 at an edge SHALL force EMPTY, discarding any same-cycle push and pop.
REQ-036 When out_valid=0, ia, ib, aluOp and illegal SHALL be 0.
REQ-037 Entry order SHALL be preserved across wrap-around of the internal read/write pointers.

Reset
REQ-038 While reset_n=0 the block SHALL be EMPTY.
REQ-039 While reset_n=0 the outputs SHALL be in_ready=1, out_valid=0, ia=0, ib=0, aluOp=0, illegal=0.
REQ-040 Reset assertion mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-041 The first push SHALL be accepted at the first rising edge after reset_n rises.

Verification
REQ-042 Decode scenario: is_imm=0, funct3=000, funct7_5=1, rs1=10, rs2=3, out_ready=1 -> next cycle out_valid=1, aluOp=001, ia=10, ib=3, illegal=0.
REQ-043 Shift scenario: is_imm=1, funct3=101, funct7_5=1, imm=0x47F -> aluOp=111, ib=0x3F.
REQ-044 Back-pressure scenario: out_ready=0, push A, B, C on consecutive cycles -> A, B accepted; in_ready=0 after the second push; C held off; outputs stable showing A. Then out_ready=1 -> A, B, C emerge in order, one per cycle.
REQ-045 Illegal scenario: funct3=010 -> aluOp=000, illegal=1, out_valid=1.
REQ-046 Flush scenario: FULL, then flush=1 together with in_valid=1 -> next cycle out_valid=0, in_ready=1; the concurrent instruction never appears.
REQ-047 Reset scenario: FULL, then assert reset_n=0 between edges -> out_valid=0 and all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: decodes RISC-V OP/OP-IMM ALU instructions at enqueue and holds
// them in a 2-entry skid FIFO ahead of the ALU stage. in_ready/out_valid come
// straight from registers so there is no combinational path from out_ready
// back to in_ready.
module alu_issue (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        is_imm,
  input  logic [63:0] rs1_val,
  input  logic [63:0] rs2_val,
  input  logic [63:0] imm,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] ia,
  output logic [63:0] ib,
  output logic [2:0]  aluOp,
  output logic        illegal
);

  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_XOR = 3'b010,
                         OP_OR  = 3'b011, OP_AND = 3'b100, OP_SLL = 3'b101,
                         OP_SRL = 3'b110, OP_SRA = 3'b111;

  typedef struct packed {
    logic [63:0] ia;
    logic [63:0] ib;
    logic [2:0]  op;
    logic        illegal;
  } entryT;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} stateT;

  stateT state, stateNext;
  logic  wrPtr, rdPtr;
  logic  inReadyQ, outValidQ;
  logic  push, pop;
  entryT dec, head;
  entryT mem [2];
  logic [63:0] src;

  assign push = in_valid && inReadyQ;
  assign pop  = outValidQ && out_ready;

  // Decode the incoming instruction into the entry format stored in the FIFO
  always_comb begin
    src         = is_imm ? imm : rs2_val;
    dec         = '0;
    dec.ia      = rs1_val;
    dec.ib      = src;
    dec.op      = OP_ADD;
    dec.illegal = 1'b0;
    case (funct3)
      3'b000: dec.op = (!is_imm && funct7_5) ? OP_SUB : OP_ADD;
      3'b001: begin
        dec.op = OP_SLL;
        dec.ib = {58'b0, src[5:0]};
      end
      3'b010, 3'b011: dec.illegal = 1'b1;  // slt/sltu not handled here
      3'b100: dec.op = OP_XOR;
      3'b101: begin
        dec.op = funct7_5 ? OP_SRA : OP_SRL;
        dec.ib = {58'b0, src[5:0]};
      end
      3'b110: dec.op = OP_OR;
      3'b111: dec.op = OP_AND;
      default: dec.op = OP_ADD;
    endcase
  end

  // Occupancy next-state; FULL never sees a push because in_ready is low
  always_comb begin
    stateNext = state;
    case (state)
      EMPTY:   if (push) stateNext = ONE;
      ONE:     if (push && !pop) stateNext = FULL;
               else if (pop && !push) stateNext = EMPTY;
      FULL:    if (pop) stateNext = ONE;
      default: stateNext = EMPTY;
    endcase
    if (flush) stateNext = EMPTY;
  end

  // State, pointers and registered handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      wrPtr     <= 1'b0;
      rdPtr     <= 1'b0;
      inReadyQ  <= 1'b1;
      outValidQ <= 1'b0;
    end else begin
      state     <= stateNext;
      inReadyQ  <= (stateNext != FULL);
      outValidQ <= (stateNext != EMPTY);
      if (flush) begin
        wrPtr <= 1'b0;
        rdPtr <= 1'b0;
      end else begin
        wrPtr <= wrPtr ^ push;
        rdPtr <= rdPtr ^ pop;
      end
    end
  end

  // Entry storage; contents are don't-care until the pointers make them live
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wrPtr] <= dec;
  end

  assign head      = mem[rdPtr];
  assign in_ready  = inReadyQ;
  assign out_valid = outValidQ;
  assign ia        = outValidQ ? head.ia      : 64'd0;
  assign ib        = outValidQ ? head.ib      : 64'd0;
  assign aluOp     = outValidQ ? head.op      : 3'd0;
  assign illegal   = outValidQ ? head.illegal : 1'b0;

endmodule
